// File: rtl/wr_sched_pkg.sv
// wr_sched_pkg: shared types and constants for the write row scheduler
// state_t     : scheduler FSM states
// cmd_mode_t  : fixed-width descriptor fields forwarded to the write controller
// WD_LIMIT    : watchdog terminal count (used when WR_SCHED_TIMEOUT_EN is defined)
package wr_sched_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CONF,
    S_WAIT_START,
    S_WAIT_IDLE,
    S_NEXT
  } state_t;
  typedef struct packed {
    logic [1:0] valid_mac;
    logic       pooled;
    logic       is_relu;
    logic [4:0] shift_len;
  } cmd_mode_t;
  localparam logic [15:0] WD_LIMIT = 16'hFFFF;
endpackage

// File: rtl/wr_row_scheduler_if.sv
// wr_row_scheduler_if: descriptor, write-controller and status bundle of wr_row_scheduler
// descriptor : cmd_valid/cmd_ready handshake plus cmd_* fields
// write ctrl : conf_input pulse, st_addr/linelen/valid_mac/pooled/is_relu/shift_len, wc_req, wc_idle
// status     : flush in; busy, done, row_cnt, err out
// slave = scheduler side, master = producer / write controller / observer side
interface wr_row_scheduler_if #(
  parameter int ADDR_LEN     = 13,
  parameter int X_MAC        = 4,
  parameter int MAX_LINE_LEN = 10,
  parameter int ROW_LEN      = 10
);
  logic                      cmd_valid;
  logic                      cmd_ready;
  logic [ADDR_LEN*X_MAC-1:0] cmd_st_addr;
  logic [ADDR_LEN-1:0]       cmd_stride;
  logic [ROW_LEN-1:0]        cmd_rows;
  logic [MAX_LINE_LEN-1:0]   cmd_linelen;
  logic [1:0]                cmd_valid_mac;
  logic                      cmd_pooled;
  logic                      cmd_is_relu;
  logic [4:0]                cmd_shift_len;
  logic                      conf_input;
  logic [ADDR_LEN*X_MAC-1:0] st_addr;
  logic [MAX_LINE_LEN-1:0]   linelen;
  logic [1:0]                valid_mac;
  logic                      pooled;
  logic                      is_relu;
  logic [4:0]                shift_len;
  logic                      wc_req;
  logic                      wc_idle;
  logic                      flush;
  logic                      busy;
  logic                      done;
  logic [ROW_LEN-1:0]        row_cnt;
  logic                      err;
  modport slave (
    input  cmd_valid, cmd_st_addr, cmd_stride, cmd_rows, cmd_linelen,
           cmd_valid_mac, cmd_pooled, cmd_is_relu, cmd_shift_len,
           wc_req, wc_idle, flush,
    output cmd_ready, conf_input, st_addr, linelen, valid_mac, pooled,
           is_relu, shift_len, busy, done, row_cnt, err
  );
  modport master (
    output cmd_valid, cmd_st_addr, cmd_stride, cmd_rows, cmd_linelen,
           cmd_valid_mac, cmd_pooled, cmd_is_relu, cmd_shift_len,
           wc_req, wc_idle, flush,
    input  cmd_ready, conf_input, st_addr, linelen, valid_mac, pooled,
           is_relu, shift_len, busy, done, row_cnt, err
  );
endinterface

// File: rtl/wr_cmd_fifo.sv
// wr_cmd_fifo: synchronous DEPTH-entry descriptor FIFO with same-cycle flush
// clk, rst  : clock, async active-high reset
// push, din : write (ignored when full or flushing)
// pop, dout : read (dout shows the head entry)
// flush     : empties the FIFO at the next edge, dropping a concurrent push
// full, empty : occupancy flags
module wr_cmd_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic          do_push, do_pop;
  assign full    = cnt == CW'(DEPTH);
  assign empty   = cnt == '0;
  assign dout    = mem[rp];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else if (flush) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push && !flush) mem[wp] <= din;
endmodule

// File: rtl/wr_row_scheduler.sv
// wr_row_scheduler: queues row descriptors and sequences per-row write-controller configuration
// clk, rst : clock, async active-high reset
// bus      : wr_row_scheduler_if.slave (descriptor handshake, write-controller config, status)
// Build option: define WR_SCHED_TIMEOUT_EN to enable the 16-bit wait-state watchdog driving err;
// otherwise err is tied low.
module wr_row_scheduler
  import wr_sched_pkg::*;
#(
  parameter int ADDR_LEN     = 13,
  parameter int X_MAC        = 4,
  parameter int MAX_LINE_LEN = 10,
  parameter int ROW_LEN      = 10,
  parameter int CMD_DEPTH    = 4
) (
  input logic              clk,
  input logic              rst,
  wr_row_scheduler_if.slave bus
);
  typedef logic [X_MAC-1:0][ADDR_LEN-1:0] lanes_t;
  localparam int DW = $bits(lanes_t) + ADDR_LEN + ROW_LEN + MAX_LINE_LEN + $bits(cmd_mode_t);
  state_t                  state, state_nx;
  logic [DW-1:0]           fifo_in, fifo_out;
  logic                    full, empty, pop, accept;
  logic                    retire, last, stop, flush_pend, timeout;
  lanes_t                  f_addr, addr;
  logic [ADDR_LEN-1:0]     f_stride, stride;
  logic [ROW_LEN-1:0]      f_rows, rows, row_cnt;
  logic [MAX_LINE_LEN-1:0] f_len, linelen;
  cmd_mode_t               f_mode, mode;
  assign bus.cmd_ready = !full && !rst;
  assign accept  = bus.cmd_valid && bus.cmd_ready;
  // a flush in the same cycle must not let the head escape into the engine
  assign pop     = state == S_IDLE && !empty && !bus.flush;
  assign fifo_in = {bus.cmd_st_addr, bus.cmd_stride, bus.cmd_rows, bus.cmd_linelen,
                    bus.cmd_valid_mac, bus.cmd_pooled, bus.cmd_is_relu, bus.cmd_shift_len};
  assign {f_addr, f_stride, f_rows, f_len, f_mode} = fifo_out;
  wr_cmd_fifo #(.W(DW), .DEPTH(CMD_DEPTH)) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (accept),
    .pop  (pop),
    .flush(bus.flush),
    .din  (fifo_in),
    .dout (fifo_out),
    .full (full),
    .empty(empty)
  );
`ifdef WR_SCHED_TIMEOUT_EN
  logic [15:0] wd;
  logic        waiting;
  assign waiting = state == S_WAIT_START || state == S_WAIT_IDLE;
  assign timeout = waiting && wd == WD_LIMIT;
  always_ff @(posedge clk or posedge rst)
    if (rst) wd <= '0;
    else wd <= waiting && !timeout ? wd + 1'b1 : '0;
`else
  assign timeout = 1'b0;
`endif
  assign last = ROW_LEN'(row_cnt + 1'b1) == rows;
  assign stop = bus.flush || flush_pend;
  always_comb begin
    state_nx = state;
    retire   = 1'b0;
    case (state)
      S_IDLE:       state_nx = pop ? S_LOAD : S_IDLE;
      S_LOAD: begin
        retire   = rows == '0 || linelen == '0 || stop;
        state_nx = retire ? S_IDLE : S_CONF;
      end
      S_CONF:       state_nx = S_WAIT_START;
      S_WAIT_START: state_nx = timeout ? S_IDLE : bus.wc_req ? S_WAIT_IDLE : S_WAIT_START;
      S_WAIT_IDLE:  state_nx = timeout ? S_IDLE : bus.wc_idle ? S_NEXT : S_WAIT_IDLE;
      S_NEXT: begin
        retire   = last || stop;
        state_nx = retire ? S_IDLE : S_CONF;
      end
      default:      state_nx = S_IDLE;
    endcase
  end
  // descriptor fields are captured on the pop edge, so they are valid throughout S_LOAD
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state      <= S_IDLE;
      flush_pend <= 1'b0;
      addr       <= '0;
      stride     <= '0;
      rows       <= '0;
      linelen    <= '0;
      mode       <= '0;
      row_cnt    <= '0;
    end else begin
      state      <= state_nx;
      flush_pend <= state_nx != S_IDLE && (flush_pend || bus.flush);
      if (pop) begin
        addr    <= f_addr;
        stride  <= f_stride;
        rows    <= f_rows;
        linelen <= f_len;
        mode    <= f_mode;
        row_cnt <= '0;
      end else if (state == S_NEXT) begin
        row_cnt <= row_cnt + 1'b1;
        for (int i = 0; i < X_MAC; i++) addr[i] <= addr[i] + stride;
      end
    end
  assign bus.conf_input = state == S_CONF;
  assign bus.done       = retire;
  assign bus.err        = timeout;
  assign bus.busy       = state != S_IDLE || !empty;
  assign bus.st_addr    = addr;
  assign bus.linelen    = linelen;
  assign bus.valid_mac  = mode.valid_mac;
  assign bus.pooled     = mode.pooled;
  assign bus.is_relu    = mode.is_relu;
  assign bus.shift_len  = mode.shift_len;
  assign bus.row_cnt    = row_cnt;
endmodule

// File: tb/tb_wr_row_scheduler.sv
// tb_wr_row_scheduler: directed vector table plus hand sequences for wr_row_scheduler
module tb_wr_row_scheduler;
  typedef struct {
    logic [12:0] a0, a1, a2, a3, stride;
    logic [9:0]  rows, len;
    logic [8:0]  mode;
    int          n_conf;
    logic [12:0] c_first, c_second, c_last, fin0, fin3;
  } vec_t;
  logic clk = 1'b0;
  logic rst;
  logic wc_auto, m_req, m_idle, t_req, t_idle;
  int   n_cmp = 0, n_err = 0;
  int   conf_n = 0, done_n = 0, err_n = 0;
  logic [12:0] conf_a0 [256];
  vec_t vt [5];
  always #5 clk = ~clk;
  wr_row_scheduler_if bus ();
  assign bus.wc_req  = wc_auto ? m_req : t_req;
  assign bus.wc_idle = wc_auto ? m_idle : t_idle;
  wr_row_scheduler dut (.clk(clk), .rst(rst), .bus(bus));
  initial forever begin
    @(negedge clk);
    if (bus.conf_input) begin
      if (conf_n < 256) conf_a0[conf_n] = bus.st_addr[12:0];
      conf_n++;
    end
    if (bus.done) done_n++;
    if (bus.err) err_n++;
  end
  initial begin
    m_req  = 1'b0;
    m_idle = 1'b1;
    forever begin
      @(negedge clk);
      if (wc_auto && bus.conf_input) begin
        m_idle = 1'b0;
        repeat (12) @(negedge clk);
        m_req = 1'b1;
        @(negedge clk);
        m_req = 1'b0;
        repeat (2) @(negedge clk);
        m_idle = 1'b1;
      end
    end
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic push(input vec_t v);
    bus.cmd_st_addr = {v.a3, v.a2, v.a1, v.a0};
    bus.cmd_stride  = v.stride;
    bus.cmd_rows    = v.rows;
    bus.cmd_linelen = v.len;
    {bus.cmd_valid_mac, bus.cmd_pooled, bus.cmd_is_relu, bus.cmd_shift_len} = v.mode;
    bus.cmd_valid = 1'b1;
    cyc(1);
    bus.cmd_valid = 1'b0;
  endtask
  task automatic wait_done(input int d0, input int lim);
    int k = 0;
    while (done_n == d0 && k < lim) begin
      cyc(1);
      k++;
    end
    chk("done_seen", 64'(done_n != d0), 1);
  endtask
  function automatic vec_t mk(input logic [12:0] a, input logic [12:0] s,
                              input logic [9:0] r, input logic [9:0] l);
    vec_t v = '{default: 0};
    v.a0 = a;
    v.a1 = a + 13'd1;
    v.a2 = a + 13'd2;
    v.a3 = a + 13'd3;
    v.stride = s;
    v.rows = r;
    v.len = l;
    v.mode = 9'h0AA;
    return v;
  endfunction
  initial begin
    int c0, c1, d0, acc, k;
    vt[0] = '{13'd0, 13'd100, 13'd200, 13'd300, 13'd8, 10'd3, 10'd16, 9'h1A5, 3,
              13'd0, 13'd8, 13'd16, 13'd24, 13'd324};
    vt[1] = '{13'd8190, 13'd10, 13'd20, 13'd8191, 13'd4, 10'd2, 10'd1, 9'h003, 2,
              13'd8190, 13'd2, 13'd2, 13'd6, 13'd7};
    vt[2] = '{13'd5, 13'd6, 13'd7, 13'd8, 13'd3, 10'd0, 10'd5, 9'h1FF, 0,
              13'd0, 13'd0, 13'd0, 13'd5, 13'd8};
    vt[3] = '{13'd1, 13'd2, 13'd3, 13'd4, 13'd9, 10'd2, 10'd0, 9'h040, 0,
              13'd0, 13'd0, 13'd0, 13'd1, 13'd4};
    vt[4] = '{13'd1, 13'd0, 13'd8191, 13'd4096, 13'd8191, 10'd1, 10'd1023, 9'h100, 1,
              13'd1, 13'd0, 13'd1, 13'd0, 13'd4095};
    rst = 1'b1;
    wc_auto = 1'b0;
    t_req = 1'b0;
    t_idle = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.flush = 1'b0;
    bus.cmd_st_addr = '0;
    bus.cmd_stride = '0;
    bus.cmd_rows = '0;
    bus.cmd_linelen = '0;
    {bus.cmd_valid_mac, bus.cmd_pooled, bus.cmd_is_relu, bus.cmd_shift_len} = '0;
    cyc(2);
    chk("rst_cmd_ready", bus.cmd_ready, 0);
    chk("rst_conf", bus.conf_input, 0);
    @(negedge clk);
    rst = 1'b0;
    cyc(1);
    chk("idle_cmd_ready", bus.cmd_ready, 1);
    chk("idle_busy", bus.busy, 0);
    chk("idle_done", bus.done, 0);
    chk("idle_row_cnt", bus.row_cnt, 0);
    chk("idle_st_addr", bus.st_addr, 0);
    chk("idle_err", bus.err, 0);
    // back-to-back empty descriptors: done one cycle after accept, S_IDLE once between
    push(mk(13'd10, 13'd1, 10'd0, 10'd4));
    push(mk(13'd20, 13'd1, 10'd0, 10'd4));
    chk("b2b_done_a", bus.done, 1);
    cyc(1);
    chk("b2b_gap", bus.done, 0);
    cyc(1);
    chk("b2b_done_b", bus.done, 1);
    chk("b2b_conf", bus.conf_input, 0);
    cyc(1);
    chk("b2b_end_done", bus.done, 0);
    chk("b2b_end_busy", bus.busy, 0);
    wc_auto = 1'b1;
    for (int i = 0; i < 5; i++) begin
      c0 = conf_n;
      d0 = done_n;
      push(vt[i]);
      wait_done(d0, 500);
      cyc(3);
      chk("vec_conf_count", conf_n - c0, vt[i].n_conf);
      chk("vec_done_count", done_n - d0, 1);
      chk("vec_row_cnt", bus.row_cnt, vt[i].n_conf);
      chk("vec_lane0_final", bus.st_addr[12:0], vt[i].fin0);
      chk("vec_lane3_final", bus.st_addr[51:39], vt[i].fin3);
      chk("vec_linelen", bus.linelen, vt[i].len);
      chk("vec_mode", {bus.valid_mac, bus.pooled, bus.is_relu, bus.shift_len}, vt[i].mode);
      chk("vec_busy", bus.busy, 0);
      if (vt[i].n_conf > 0) begin
        chk("vec_conf_first_addr", conf_a0[c0], vt[i].c_first);
        chk("vec_conf_last_addr", conf_a0[c0 + vt[i].n_conf - 1], vt[i].c_last);
      end
      if (vt[i].n_conf > 1) chk("vec_conf_second_addr", conf_a0[c0 + 1], vt[i].c_second);
    end
    wc_auto = 1'b0;
    // latency, idle-alone does not complete a row, reset while waiting for idle
    t_idle = 1'b1;
    d0 = done_n;
    push(mk(13'd40, 13'd2, 10'd2, 10'd4));
    chk("lat_busy_n", bus.busy, 1);
    cyc(1);
    chk("lat_conf_n1", bus.conf_input, 0);
    cyc(1);
    chk("lat_conf_n2", bus.conf_input, 1);
    chk("lat_linelen", bus.linelen, 4);
    cyc(1);
    chk("lat_conf_n3", bus.conf_input, 0);
    cyc(5);
    chk("idle_only_row_cnt", bus.row_cnt, 0);
    chk("idle_only_done", done_n - d0, 0);
    t_idle = 1'b0;
    t_req = 1'b1;
    cyc(1);
    t_req = 1'b0;
    chk("mid_row_addr", bus.st_addr[12:0], 40);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_conf", bus.conf_input, 0);
    chk("async_rst_busy", bus.busy, 0);
    chk("async_rst_st_addr", bus.st_addr, 0);
    chk("async_rst_linelen", bus.linelen, 0);
    chk("async_rst_ready", bus.cmd_ready, 0);
    c1 = conf_n;
    @(negedge clk);
    rst = 1'b0;
    t_idle = 1'b1;
    cyc(5);
    chk("post_rst_conf", conf_n - c1, 0);
    chk("post_rst_busy", bus.busy, 0);
    chk("post_rst_ready", bus.cmd_ready, 1);
    // fill the FIFO behind a blocked row, then flush mid-row
    t_idle = 1'b0;
    push(mk(13'd0, 13'd1, 10'd3, 10'd4));
    cyc(3);
    t_req = 1'b1;
    cyc(1);
    t_req = 1'b0;
    acc = 0;
    for (int j = 0; j < 5; j++) begin
      acc += int'(bus.cmd_ready);
      push(mk(13'(100 + j), 13'd1, 10'd1, 10'd1));
    end
    chk("fill_accepted", acc, 4);
    chk("fill_ready_low", bus.cmd_ready, 0);
    d0 = done_n;
    bus.flush = 1'b1;
    cyc(1);
    bus.flush = 1'b0;
    chk("flush_ready", bus.cmd_ready, 1);
    chk("flush_busy_midrow", bus.busy, 1);
    chk("flush_no_early_done", done_n - d0, 0);
    c1 = conf_n;
    t_idle = 1'b1;
    wait_done(d0, 20);
    chk("flush_row_cnt", bus.row_cnt, 1);
    cyc(1);
    chk("flush_busy_end", bus.busy, 0);
    cyc(3);
    chk("flush_no_conf", conf_n - c1, 0);
    bus.cmd_st_addr = '0;
    bus.cmd_rows = 10'd1;
    bus.cmd_linelen = 10'd1;
    bus.cmd_valid = 1'b1;
    bus.flush = 1'b1;
    cyc(1);
    bus.cmd_valid = 1'b0;
    bus.flush = 1'b0;
    chk("flush_accept_busy", bus.busy, 0);
    c1 = conf_n;
    cyc(3);
    chk("flush_accept_conf", conf_n - c1, 0);
`ifdef WR_SCHED_TIMEOUT_EN
    t_req = 1'b0;
    t_idle = 1'b1;
    d0 = done_n;
    push(mk(13'd0, 13'd1, 10'd1, 10'd1));
    k = 0;
    while (!bus.conf_input && k < 10) begin
      cyc(1);
      k++;
    end
    chk("wd_conf_seen", bus.conf_input, 1);
    k = 0;
    while (!bus.err && k < 70000) begin
      cyc(1);
      k++;
    end
    chk("wd_err_latency", k, 65536);
    cyc(1);
    chk("wd_err_pulse", bus.err, 0);
    chk("wd_busy", bus.busy, 0);
    chk("wd_no_done", done_n - d0, 0);
`else
    chk("err_tied_low", err_n, 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
